// File: rtl/isqrt_iter_responder.sv
// isqrt_iter_responder: responder side of the isqrt request/response link.
// Takes a 32-bit operand on x_vld/x and returns floor(sqrt(x)) on y_vld/y.
// A restoring digit-by-digit engine produces one root bit per cycle.
// Because the link has no backpressure, a small in-order queue holds the
// operands that arrive while the engine is busy.
module isqrt_iter_responder #(
   parameter int QDEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        x_vld,
   input  logic [31:0] x,
   output logic        y_vld,
   output logic [15:0] y,
   output logic        busy,
   output logic        overflow
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t      state, state_next;

   // Engine registers
   logic [31:0] xs;
   logic [17:0] rem;
   logic [15:0] root;
   logic [3:0]  cnt;

   // Request queue
   logic [31:0]   q_mem [QDEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] q_cnt;
   logic          q_empty, q_full;

   // Control
   logic        pop, bypass, load, push_req, push;
   logic [31:0] load_val;

   // Datapath for one iteration
   logic [17:0] r2, t, diff;
   logic        ge;
   logic [15:0] root_next;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign q_empty = (q_cnt == '0);
   assign q_full  = (q_cnt == CW'(QDEPTH));
   assign busy    = (state != IDLE) || !q_empty;

   // One restoring iteration: trial-subtract {root,01} from the shifted remainder.
   always_comb begin
      r2   = {rem[15:0], xs[31:30]};
      t    = {root, 2'b01};
      diff = r2 - t;
      // Any set bit above the 18-bit window means the true shifted remainder
      // already exceeds t; the bound rem <= 2*root keeps those bits zero.
      ge        = (rem[17:16] != 2'b00) || (r2 >= t);
      root_next = {root[14:0], ge};
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values; blocking here would create ordering races.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state, queue pop/push and engine load decisions.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_next = state;
      pop        = 1'b0;
      bypass     = 1'b0;
      case (state)
         IDLE: begin
            // A request that landed in the queue during DONE is drained here.
            if (!q_empty) begin
               pop        = 1'b1;
               state_next = ITER;
            end else if (x_vld) begin
               bypass     = 1'b1;
               state_next = ITER;
            end
         end
         ITER: if (cnt == 4'd15) state_next = DONE;
         DONE: begin
            if (!q_empty) begin
               pop        = 1'b1;
               state_next = ITER;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      load     = pop || bypass;
      load_val = pop ? q_mem[rd_ptr] : x;
      push_req = x_vld && !bypass;
      // A pop in the same cycle frees a slot, so a full queue still accepts.
      push     = push_req && (!q_full || pop);
   end

   // Engine: load an operand, then one root bit per cycle for 16 cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         xs    <= '0;
         rem   <= '0;
         root  <= '0;
         cnt   <= '0;
         y     <= '0;
         y_vld <= 1'b0;
      end else begin
         y_vld <= (state == ITER) && (cnt == 4'd15);
         if (load) begin
            xs   <= load_val;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
         end else if (state == ITER) begin
            rem  <= ge ? diff : r2;
            root <= root_next;
            xs   <= xs << 2;
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd15) y <= root_next;
         end
      end
   end

   // Queue storage.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is not reset; occupancy is tracked by q_cnt,
      // so stale entries are never read and a reset here would only add fan-out.
      if (push) q_mem[wr_ptr] <= x;
   end

   // Queue pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         q_cnt    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   q_cnt <= q_cnt + 1'b1;
            2'b01:   q_cnt <= q_cnt - 1'b1;
            default: q_cnt <= q_cnt;
         endcase
         if (push_req && q_full && !pop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_isqrt_iter_responder.sv
// Directed bench for isqrt_iter_responder: latency, queueing, overflow,
// reset mid-flight, and a random run against a binary-search reference.
module tb_isqrt_iter_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        x_vld;
   logic [31:0] x;
   logic        y_vld;
   logic [15:0] y;
   logic        busy;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   localparam int NRAND = 4000;

   isqrt_iter_responder #(.QDEPTH(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .x_vld    (x_vld),
      .x        (x),
      .y_vld    (y_vld),
      .y        (y),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Time-out guard
   initial begin
      #1500000;
      $display("FAIL timeout: simulation did not complete (checks %0d errors %0d)", checks, errors);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs and samples sit 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request in the current cycle, then advance.
   task automatic send(input logic [31:0] v);
      x_vld = 1'b1;
      x     = v;
      step();
      x_vld = 1'b0;
   endtask

   // Step until y_vld (bounded), check the wait length and value, then check
   // the pulse lasts exactly one cycle and y holds.
   task automatic await_y(input string tag, input logic [15:0] exp_y, input int exp_wait);
      int k;
      k = 0;
      while (!y_vld && k < 60) begin
         step();
         k++;
      end
      check({tag, "_wait"}, k, exp_wait);
      check({tag, "_y"}, y, exp_y);
      step();
      check({tag, "_pulse"}, y_vld, 1'b0);
      check({tag, "_hold"}, y, exp_y);
   endtask

   function automatic logic [15:0] isqrt_ref(input logic [31:0] v);
      longint lo, hi, mid;
      lo = 0;
      hi = 65535;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= longint'(v)) lo = mid;
         else                          hi = mid - 1;
      end
      return lo[15:0];
   endfunction

   initial begin
      logic [31:0] vec_x [6];
      logic [15:0] vec_y [6];
      logic [31:0] fx    [4];
      logic [15:0] fy    [4];
      logic [15:0] exp_q [$];
      logic [31:0] rv;
      int          sent, got, last_c;
      bit          seen;

      vec_x = '{32'd0, 32'd1, 32'd15, 32'd16, 32'd1000000, 32'hFFFF_FFFF};
      vec_y = '{16'd0, 16'd1, 16'd3,  16'd4,  16'd1000,    16'd65535};
      fx    = '{32'd16, 32'd8, 32'd99, 32'd10000};
      fy    = '{16'd4,  16'd2, 16'd9,  16'd100};

      // Reset
      rst   = 1'b1;
      x_vld = 1'b0;
      x     = '0;
      repeat (3) step();
      check("rst_y_vld", y_vld, 1'b0);
      check("rst_y", y, 16'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      rst = 1'b0;
      step();

      // 1. Single requests from an idle engine, 17-cycle latency
      for (int i = 0; i < 6; i++) begin
         send(vec_x[i]);
         check("single_busy", busy, 1'b1);
         await_y($sformatf("single%0d", i), vec_y[i], 16);
         check("single_idle", busy, 1'b0);
         step();
      end

      // 2. Formula-FSM pattern: next request on the cycle after each y_vld
      for (int i = 0; i < 4; i++) begin
         check($sformatf("formula%0d_busy_before", i), busy, 1'b0);
         send(fx[i]);
         await_y($sformatf("formula%0d", i), fy[i], 16);
      end
      check("formula_busy_after", busy, 1'b0);

      // 3. Burst of three: one bypass, two queued
      step();
      send(32'd81);
      send(32'd144);
      send(32'd2);
      check("burst3_overflow", overflow, 1'b0);
      await_y("burst3_a", 16'd9, 14);
      await_y("burst3_b", 16'd12, 16);
      await_y("burst3_c", 16'd1, 16);
      check("burst3_overflow_end", overflow, 1'b0);
      check("burst3_idle", busy, 1'b0);

      // 4. Burst of four: the fourth is dropped; a fifth on a DONE cycle is taken
      step();
      send(32'd25);
      send(32'd36);
      send(32'd49);
      check("burst4_no_ovf_yet", overflow, 1'b0);
      send(32'd64);
      check("burst4_overflow", overflow, 1'b1);
      repeat (13) step();
      check("burst4_done_vld", y_vld, 1'b1);
      check("burst4_done_y", y, 16'd5);
      send(32'd100);
      check("burst4_pulse", y_vld, 1'b0);
      await_y("burst4_b", 16'd6, 16);
      await_y("burst4_c", 16'd7, 16);
      await_y("burst4_e", 16'd10, 16);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (y_vld) seen = 1'b1;
         step();
      end
      check("burst4_no_extra", seen, 1'b0);
      check("burst4_overflow_sticky", overflow, 1'b1);
      check("burst4_idle", busy, 1'b0);

      // 5. Reset during a computation with one request queued
      send(32'd121);
      send(32'd144);
      repeat (6) step();
      check("rst_mid_busy_before", busy, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_y", y, 16'd0);
      check("rst_mid_overflow", overflow, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (y_vld) seen = 1'b1;
         step();
      end
      check("rst_mid_no_vld", seen, 1'b0);
      check("rst_mid_idle", busy, 1'b0);
      send(32'd49);
      await_y("rst_then_49", 16'd7, 16);

      // 6. Random operands, kept back-to-back with one entry queued
      sent   = 0;
      got    = 0;
      last_c = 0;
      step();
      for (int i = 0; i < 2; i++) begin
         rv = $urandom;
         exp_q.push_back(isqrt_ref(rv));
         send(rv);
         sent++;
      end
      for (int c = 0; c < NRAND * 17 + 200 && got < NRAND; c++) begin
         x_vld = 1'b0;
         if (y_vld) begin
            if (exp_q.size() == 0) begin
               check("rand_unexpected", y_vld, 1'b0);
            end else begin
               check($sformatf("rand%0d", got), y, exp_q.pop_front());
            end
            if (got > 0) check("rand_gap", c - last_c, 17);
            last_c = c;
            got++;
            if (sent < NRAND) begin
               rv    = $urandom;
               x_vld = 1'b1;
               x     = rv;
               exp_q.push_back(isqrt_ref(rv));
               sent++;
            end
         end
         step();
      end
      x_vld = 1'b0;
      check("rand_count", got, NRAND);
      check("rand_overflow", overflow, 1'b0);
      step();
      check("rand_idle", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
